// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the RV32 decode-stage control unit: opcodes,
// ALU operation encodings, the control bundle and the hazard FSM states.
package riscv_ctrl_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam int CTRL_ALU_OP_W = 2;

    localparam logic [CTRL_ALU_OP_W-1:0] ALU_OP_ADD = 2'b00;
    localparam logic [CTRL_ALU_OP_W-1:0] ALU_OP_BR  = 2'b01;
    localparam logic [CTRL_ALU_OP_W-1:0] ALU_OP_RFN = 2'b10;
    localparam logic [CTRL_ALU_OP_W-1:0] ALU_OP_IMM = 2'b11;

    typedef struct packed {
        logic                     branch;
        logic                     jump;
        logic                     reg_write;
        logic                     mem_to_reg;
        logic                     mem_read;
        logic                     mem_write;
        logic                     alu_src;
        logic [CTRL_ALU_OP_W-1:0] alu_op;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_BUBBLE = '0;

    typedef enum logic {
        ST_RUN,
        ST_HAZ
    } haz_state_e;

endpackage

// File: rtl/id_ctrl_decode.sv
// Purely combinational opcode decoder: produces the control bundle, the
// source-register usage flags and a flag telling whether the opcode is known.
module id_ctrl_decode
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0]   opcode_i,
    output ctrl_bundle_t ctrl_o,
    output logic         uses_rs1_o,
    output logic         uses_rs2_o,
    output logic         known_o
);

    // Opcode table; unknown opcodes fall through to the all-zero bundle.
    always_comb begin
        ctrl_o     = CTRL_BUBBLE;
        uses_rs1_o = 1'b0;
        uses_rs2_o = 1'b0;
        known_o    = 1'b1;
        case (opcode_i)
            OPC_R: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_op    = ALU_OP_RFN;
                uses_rs1_o       = 1'b1;
                uses_rs2_o       = 1'b1;
            end
            OPC_I: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.alu_op    = ALU_OP_ADD;
                uses_rs1_o       = 1'b1;
            end
            OPC_LOAD: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.mem_read   = 1'b1;
                ctrl_o.alu_src    = 1'b1;
                uses_rs1_o        = 1'b1;
            end
            OPC_STORE: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                uses_rs1_o       = 1'b1;
                uses_rs2_o       = 1'b1;
            end
            OPC_BRANCH: begin
                ctrl_o.branch = 1'b1;
                ctrl_o.alu_op = ALU_OP_BR;
                uses_rs1_o    = 1'b1;
                uses_rs2_o    = 1'b1;
            end
            OPC_JAL: begin
                ctrl_o.jump      = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            OPC_JALR: begin
                ctrl_o.jump      = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                uses_rs1_o       = 1'b1;
            end
            OPC_LUI: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.alu_op    = ALU_OP_IMM;
            end
            OPC_AUIPC: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.alu_op    = ALU_OP_ADD;
            end
            default: begin
                known_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/id_ctrl_unit.sv
// Decode-stage control unit: decodes the IF/ID instruction, detects load-use
// hazards, inserts bubbles and registers the control bundle into ID/EX.
// Optional feature: define CTRL_ILLEGAL_TRAP_EN to make illegal_o a sticky
// flag raised by a valid unknown opcode; otherwise illegal_o is tied low.
module id_ctrl_unit
    import riscv_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W      = 5,
    parameter int LOAD_USE_STALLS = 1,
    parameter int ALU_OP_W        = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           instr_i,
    input  logic                  instr_valid_i,
    input  logic                  ex_flush_i,
    input  logic                  ext_stall_i,
    output logic                  stall_o,
    output logic                  branch_o,
    output logic                  jump_o,
    output logic                  reg_write_o,
    output logic                  mem_to_reg_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic                  alu_src_o,
    output logic [ALU_OP_W-1:0]   alu_op_o,
    output logic [REG_ADDR_W-1:0] rd_o,
    output logic                  illegal_o
);

    ctrl_bundle_t          dec_ctrl;
    logic                  uses_rs1;
    logic                  uses_rs2;
    logic                  known_op;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  haz;
    logic                  stall_c;
    logic                  unused_instr;

    ctrl_bundle_t          ctrl_q, ctrl_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    haz_state_e            state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  illegal_q, illegal_d;

    id_ctrl_decode u_decode (
        .opcode_i   (instr_i[6:0]),
        .ctrl_o     (dec_ctrl),
        .uses_rs1_o (uses_rs1),
        .uses_rs2_o (uses_rs2),
        .known_o    (known_op)
    );

    assign rs1_addr     = instr_i[15 +: REG_ADDR_W];
    assign rs2_addr     = instr_i[20 +: REG_ADDR_W];
    assign rd_addr      = instr_i[7 +: REG_ADDR_W];
    assign unused_instr = ^instr_i;

    // The instruction in ID reads the register a load in EX is still fetching.
    assign haz = instr_valid_i & ctrl_q.mem_read & (rd_q != '0) &
                 ((uses_rs1 & (rs1_addr == rd_q)) | (uses_rs2 & (rs2_addr == rd_q)));

    // Next-state logic: flush beats freeze, freeze beats hazard, hazard beats issue.
    always_comb begin
        ctrl_d    = ctrl_q;
        rd_d      = rd_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        illegal_d = illegal_q;
        stall_c   = 1'b0;
        if (ex_flush_i) begin
            ctrl_d  = CTRL_BUBBLE;
            rd_d    = '0;
            state_d = ST_RUN;
            cnt_d   = 2'd0;
        end else if (ext_stall_i) begin
            stall_c = 1'b1;
        end else if (state_q == ST_HAZ) begin
            stall_c = 1'b1;
            ctrl_d  = CTRL_BUBBLE;
            rd_d    = '0;
            cnt_d   = cnt_q - 2'd1;
            if (cnt_q == 2'd1) begin
                state_d = ST_RUN;
            end
        end else if (haz) begin
            stall_c = 1'b1;
            ctrl_d  = CTRL_BUBBLE;
            rd_d    = '0;
            if (LOAD_USE_STALLS > 1) begin
                state_d = ST_HAZ;
                cnt_d   = 2'(LOAD_USE_STALLS - 1);
            end
        end else if (instr_valid_i && known_op) begin
            ctrl_d = dec_ctrl;
            rd_d   = rd_addr;
        end else begin
            ctrl_d = CTRL_BUBBLE;
            rd_d   = '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
            illegal_d = illegal_q | instr_valid_i;
`endif
        end
`ifndef CTRL_ILLEGAL_TRAP_EN
        illegal_d = 1'b0;
`endif
    end

    // ID/EX register, hazard FSM, bubble counter and sticky illegal flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= CTRL_BUBBLE;
            rd_q      <= '0;
            state_q   <= ST_RUN;
            cnt_q     <= 2'd0;
            illegal_q <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            rd_q      <= rd_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    assign stall_o      = rst_n & stall_c;
    assign branch_o     = ctrl_q.branch;
    assign jump_o       = ctrl_q.jump;
    assign reg_write_o  = ctrl_q.reg_write;
    assign mem_to_reg_o = ctrl_q.mem_to_reg;
    assign mem_read_o   = ctrl_q.mem_read;
    assign mem_write_o  = ctrl_q.mem_write;
    assign alu_src_o    = ctrl_q.alu_src;
    assign alu_op_o     = ALU_OP_W'(ctrl_q.alu_op);
    assign rd_o         = rd_q;
    assign illegal_o    = illegal_q;

endmodule

// File: tb/tb_id_ctrl_unit.sv
// Testbench for id_ctrl_unit: three instances (1, 2 and 3 load-use bubbles)
// share one stimulus stream and are compared every cycle against a
// behavioural model built from the opcode table and a bubble-remaining count.
// Honours CTRL_ILLEGAL_TRAP_EN for the illegal_o expectation.
module tb_id_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] instr = 32'd0;
    logic        valid = 1'b0;
    logic        flush = 1'b0;
    logic        ext = 1'b0;

    // Observed vector per instance: {br,jmp,rw,m2r,mrd,mwr,asrc,aop[1:0],rd[4:0],ill}
    logic [14:0] obs [3];
    logic        stallObs [3];

    int tests = 0;
    int failures = 0;

    // Reference model state
    logic [8:0] ctrlExp [3];
    logic [4:0] rdExp [3];
    int         remainExp [3];
    logic       illExp [3];
    logic       lastStall [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic       br, jmp, rw, m2r, mrd, mwr, asrc, ill, stl;
        logic [1:0] aop;
        logic [4:0] rd;
        id_ctrl_unit #(
            .REG_ADDR_W      (5),
            .LOAD_USE_STALLS (g + 1),
            .ALU_OP_W        (2)
        ) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .instr_i       (instr),
            .instr_valid_i (valid),
            .ex_flush_i    (flush),
            .ext_stall_i   (ext),
            .stall_o       (stl),
            .branch_o      (br),
            .jump_o        (jmp),
            .reg_write_o   (rw),
            .mem_to_reg_o  (m2r),
            .mem_read_o    (mrd),
            .mem_write_o   (mwr),
            .alu_src_o     (asrc),
            .alu_op_o      (aop),
            .rd_o          (rd),
            .illegal_o     (ill)
        );
        assign obs[g]      = {br, jmp, rw, m2r, mrd, mwr, asrc, aop, rd, ill};
        assign stallObs[g] = stl;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // {known, uses_rs1, uses_rs2, br, jmp, rw, m2r, mrd, mwr, asrc, aop[1:0]}
    function automatic logic [11:0] refDecode(input logic [6:0] op);
        case (op)
            7'b0110011: return {3'b111, 9'b001000010};
            7'b0010011: return {3'b110, 9'b001000100};
            7'b0000011: return {3'b110, 9'b001110100};
            7'b0100011: return {3'b111, 9'b000001100};
            7'b1100011: return {3'b111, 9'b100000001};
            7'b1101111: return {3'b100, 9'b011000000};
            7'b1100111: return {3'b110, 9'b011000100};
            7'b0110111: return {3'b100, 9'b001000111};
            7'b0010111: return {3'b100, 9'b001000100};
            default:    return 12'd0;
        endcase
    endfunction

    function automatic logic refHaz(input int k);
        logic [11:0] d;
        d = refDecode(instr[6:0]);
        return valid && ctrlExp[k][4] && (rdExp[k] != 5'd0) &&
               ((d[10] && (instr[19:15] == rdExp[k])) || (d[9] && (instr[24:20] == rdExp[k])));
    endfunction

    function automatic logic refStall(input int k);
        return !flush && (ext || (remainExp[k] > 0) || refHaz(k));
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 3; k++) begin
            ctrlExp[k]   = 9'd0;
            rdExp[k]     = 5'd0;
            remainExp[k] = 0;
            illExp[k]    = 1'b0;
        end
    endtask

    task automatic modelEdge();
        for (int k = 0; k < 3; k++) begin
            logic [11:0] d;
            logic        h;
            d = refDecode(instr[6:0]);
            h = refHaz(k);
            if (flush) begin
                ctrlExp[k] = 9'd0; rdExp[k] = 5'd0; remainExp[k] = 0;
            end else if (ext) begin
                // everything holds
            end else if (remainExp[k] > 0) begin
                ctrlExp[k] = 9'd0; rdExp[k] = 5'd0; remainExp[k]--;
            end else if (h) begin
                ctrlExp[k] = 9'd0; rdExp[k] = 5'd0; remainExp[k] = k;
            end else if (valid && d[11]) begin
                ctrlExp[k] = d[8:0]; rdExp[k] = instr[11:7];
            end else begin
                ctrlExp[k] = 9'd0; rdExp[k] = 5'd0;
`ifdef CTRL_ILLEGAL_TRAP_EN
                if (valid) illExp[k] = 1'b1;
`endif
            end
        end
    endtask

    task automatic stepCycle();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            lastStall[k] = stallObs[k];
            checkOutput($sformatf("stall_dut%0d", k), 32'(stallObs[k]), 32'(refStall(k)));
        end
        @(posedge clk);
        modelEdge();
        #1;
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("idex_dut%0d", k), 32'(obs[k]), 32'({ctrlExp[k], rdExp[k], illExp[k]}));
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic fl, input logic es);
        valid = v; instr = ins; flush = fl; ext = es;
        stepCycle();
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("reset_idex_dut%0d", k), 32'(obs[k]), 32'd0);
            checkOutput($sformatf("reset_stall_dut%0d", k), 32'(stallObs[k]), 32'd0);
        end
        modelReset();
        valid = 1'b0; flush = 1'b0; ext = 1'b0; instr = 32'd0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] randInstr();
        logic [6:0] ops [10];
        logic [31:0] r;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0000011};
        r = $urandom;
        r[11:7]  = 5'($urandom_range(0, 3));
        r[19:15] = 5'($urandom_range(0, 3));
        r[24:20] = 5'($urandom_range(0, 3));
        if ($urandom_range(0, 49) == 0) r[6:0] = 7'b1111111;
        else r[6:0] = ops[$urandom_range(0, 9)];
        return r;
    endfunction

    initial begin
        int stallCnt [3];
        modelReset();
        #2;
        instr = 32'h0000A283; valid = 1'b1; ext = 1'b1;
        applyReset();

        // Basic issue of add x3,x1,x2
        applyStimulus(1'b1, 32'h002081B3, 1'b0, 1'b0);
        checkOutput("basic_add", 32'(obs[0]), 32'({9'b001000010, 5'd3, 1'b0}));

        // Load-use: lw x5 then dependent add x6,x5,x2 held in ID
        applyStimulus(1'b1, 32'h0000A283, 1'b0, 1'b0);
        stallCnt = '{0, 0, 0};
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b1, 32'h00228333, 1'b0, 1'b0);
            for (int k = 0; k < 3; k++) stallCnt[k] += int'(lastStall[k]);
        end
        for (int k = 0; k < 3; k++)
            checkOutput($sformatf("loaduse_stalls_dut%0d", k), 32'(stallCnt[k]), 32'(k + 1));
        checkOutput("loaduse_add_rd", 32'(obs[0][5:1]), 32'd6);

        // Load to x0 never stalls
        applyStimulus(1'b1, 32'h00002003, 1'b0, 1'b0);
        stallCnt = '{0, 0, 0};
        for (int c = 0; c < 2; c++) begin
            applyStimulus(1'b1, 32'h00200333, 1'b0, 1'b0);
            for (int k = 0; k < 3; k++) stallCnt[k] += int'(lastStall[k]);
        end
        for (int k = 0; k < 3; k++)
            checkOutput($sformatf("x0_nostall_dut%0d", k), 32'(stallCnt[k]), 32'd0);

        // Flush together with freeze while in the hazard window
        applyStimulus(1'b1, 32'h0000A283, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00228333, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00228333, 1'b1, 1'b1);
        checkOutput("flush_stall_dut2", 32'(lastStall[2]), 32'd0);
        checkOutput("flush_bubble_dut2", 32'(obs[2]), 32'd0);
        applyStimulus(1'b1, 32'h00228333, 1'b0, 1'b0);
        checkOutput("after_flush_stall_dut2", 32'(lastStall[2]), 32'd0);

        // Reset asserted mid-hazard with freeze active
        applyStimulus(1'b1, 32'h0000A283, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00228333, 1'b0, 1'b0);
        valid = 1'b1; instr = 32'h00228333; ext = 1'b1;
        #2;
        applyReset();

        // Illegal opcode followed by five valid instructions
        applyStimulus(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
        checkOutput("illegal_bubble", 32'(obs[0][14:1]), 32'd0);
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b1, 32'h002081B3, 1'b0, 1'b0);
`ifdef CTRL_ILLEGAL_TRAP_EN
            checkOutput("illegal_hold", 32'(obs[0][0]), 32'd1);
`else
            checkOutput("illegal_tied", 32'(obs[0][0]), 32'd0);
`endif
        end

        // Randomized traffic
        applyReset();
        for (int c = 0; c < 400; c++) begin
            applyStimulus(($urandom_range(0, 9) != 0), randInstr(),
                          ($urandom_range(0, 11) == 0), ($urandom_range(0, 7) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
